// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t     : receiver FSM state encoding
//   OVERSAMPLE_DEF : default number of b_tick pulses per bit period
//   START_MID      : tick index of the mid-start-bit sample at the default rate
//   parity8        : parity of an 8-bit value (narrower data zero-extended)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int START_MID      = OVERSAMPLE_DEF / 2 - 1;

    // Parity of the data byte, inverted for odd sense. Zero-extending a
    // narrower word does not change the XOR reduction.
    function automatic logic parity8(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// ---------------------------------------------------------------------------
// uart_bit_sync
// Two-flop synchroniser for a single asynchronous bit. Both stages reset to 1
// so an idle-high serial line does not look like a start edge after reset.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input
//   q   : synchronised output
// ---------------------------------------------------------------------------
module uart_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchroniser, reset to the idle line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// Oversampling UART receiver front end. Synchronises rx, qualifies the start
// bit at mid-bit, samples DATA_BITS data bits LSB first at mid-bit and checks
// the stop bit. A good frame updates rx_data and pulses rx_done (RX FIFO write).
// Optional parity checking is compiled in with the macro UART_RX_PARITY_EN.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   b_tick     : oversample tick, OVERSAMPLE pulses per bit period
//   rx         : asynchronous serial input, idles high
//   rx_data    : last good byte, held until the next rx_done
//   rx_done    : one-cycle strobe, rx_data valid
//   frame_err  : one-cycle strobe, stop bit sampled low
//   parity_err : one-cycle strobe, parity mismatch (0 without the macro)
//   rx_busy    : high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // Elaboration-time parameter sanity checks
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
        $error("uart_rx_deframer: DATA_BITS must be 5..8");
    end
    if ((OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_deframer: OVERSAMPLE must be even");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_rx_deframer: PARITY_ODD must be 0 or 1");
    end

    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_done;
    logic                 r_frame_err;
    logic                 r_busy;

    uart_bit_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic       r_par_bit;
    logic       r_parity_err;
    logic [7:0] w_par_src;
    logic       w_par_bad;

    // Zero-extend the assembled word for the parity helper
    always_comb begin
        w_par_src                  = 8'h00;
        w_par_src[DATA_BITS-1:0]   = r_shift;
        w_par_bad                  = (r_par_bit != parity8(w_par_src, 1'(PARITY_ODD)));
    end
`endif

    // Receiver FSM: start qualification, mid-bit sampling, stop check, strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tick_cnt   <= {TW{1'b0}};
            r_bit_cnt    <= {BW{1'b0}};
            r_shift      <= {DATA_BITS{1'b0}};
            r_rx_data    <= {DATA_BITS{1'b0}};
            r_rx_done    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-armed below
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    // Leaving IDLE needs no tick: the tick grid is re-based here
                    if (!w_rx_s) begin
                        r_tick_cnt <= {TW{1'b0}};
                        r_state    <= START;
                        r_busy     <= 1'b1;
                    end
                end

                START: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_MID) begin
                            if (!w_rx_s) begin
                                r_tick_cnt <= {TW{1'b0}};
                                r_bit_cnt  <= {BW{1'b0}};
                                r_state    <= DATA;
                            end else begin
                                // Line back high at mid-start: treat as a glitch
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= {TW{1'b0}};
                            // Shift right so the first bit received ends at the LSB
                            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= {TW{1'b0}};
                            r_par_bit  <= w_rx_s;
                            r_state    <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
`endif

                STOP: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= {TW{1'b0}};
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= w_par_bad;
`endif
                            if (w_rx_s) begin
                                // Return to IDLE at mid-stop so a prompt next start is seen
                                r_rx_data <= r_shift;
                                r_rx_done <= 1'b1;
                                r_state   <= IDLE;
                                r_busy    <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end

                BREAK: begin
                    // Hold off until the line idles so a break cannot retrigger START
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign rx_busy   = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
// Directed frames with hand-computed expectations. Each frame pushes its
// expected strobe into a queue; an independent monitor pops and compares
// whenever the DUT raises rx_done, frame_err or parity_err, and also flags
// any rx_data change that is not accompanied by rx_done.
// b_tick is one clock in every TICK_DIV clocks.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int PARITY_ODD = 0;
    localparam int TICK_DIV   = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       b_tick = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       done;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] hold_data = 8'h00;
    logic [7:0] prev_data = 8'h00;

    uart_rx_deframer #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .b_tick     (b_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    // b_tick generator, updated on the falling edge
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            b_tick = (cnt == TICK_DIV - 1);
            cnt    = (cnt + 1) % TICK_DIV;
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Drive lvl for n b_tick periods; rx changes 1 time unit after a tick edge
    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (b_tick !== 1'b1) @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic stop_lvl, input logic perr);
        exp_t e;
        e.done = stop_lvl;
        e.ferr = ~stop_lvl;
        e.perr = perr;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_body(input logic [7:0] d);
        hold(1'b0, OVERSAMPLE);
        for (int i = 0; i < DATA_BITS; i++) begin
            hold(d[i], OVERSAMPLE);
        end
    endtask

    // Frame with correct parity (when parity is compiled in)
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
`ifdef UART_RX_PARITY_EN
        logic par;
        par = (^d) ^ 1'(PARITY_ODD);
`endif
        push_exp(d, stop_lvl, 1'b0);
        send_body(d);
`ifdef UART_RX_PARITY_EN
        hold(par, OVERSAMPLE);
`endif
        hold(stop_lvl, OVERSAMPLE);
    endtask

`ifdef UART_RX_PARITY_EN
    // Good-stop frame with an explicitly chosen parity bit
    task automatic send_frame_p(input logic [7:0] d, input logic par_lvl);
        push_exp(d, 1'b1, par_lvl != ((^d) ^ 1'(PARITY_ODD)));
        send_body(d);
        hold(par_lvl, OVERSAMPLE);
        hold(1'b1, OVERSAMPLE);
    endtask
`endif

    // Scoreboard monitor, sampling on the falling edge
    initial begin
        exp_t       e;
        logic [7:0] want_data;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_data = 8'h00;
            end else if (rx_done || frame_err || parity_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe got done=%b ferr=%b perr=%b data=%h want no strobe at %0t",
                             rx_done, frame_err, parity_err, rx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    want_data = e.done ? e.data : hold_data;
                    if ({rx_done, frame_err, parity_err, rx_data} !== {e.done, e.ferr, e.perr, want_data}) begin
                        failures++;
                        $display("FAIL strobe got done=%b ferr=%b perr=%b data=%h want done=%b ferr=%b perr=%b data=%h at %0t",
                                 rx_done, frame_err, parity_err, rx_data,
                                 e.done, e.ferr, e.perr, want_data, $time);
                    end
                    if (e.done) hold_data = e.data;
                end
            end else if (rx_data !== prev_data) begin
                checks++;
                if (rx_data !== hold_data) begin
                    failures++;
                    $display("FAIL data_stable got=%h want=%h at %0t", rx_data, hold_data, $time);
                end
            end
            prev_data = rx_data;
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_done", {7'd0, rx_done}, 8'h00);
        chk("rst_frame_err", {7'd0, frame_err}, 8'h00);
        chk("rst_parity_err", {7'd0, parity_err}, 8'h00);
        chk("rst_rx_busy", {7'd0, rx_busy}, 8'h00);
        rst = 1'b0;
        hold(1'b1, 20);

        // Good 0x55 frame
        send_frame(8'h55, 1'b1);
        chk("busy_after_55", {7'd0, rx_busy}, 8'h00);
        hold(1'b1, 8);

        // Start glitch of 4 ticks, rejected at the mid-start sample
        hold(1'b0, 4);
        chk("busy_in_glitch", {7'd0, rx_busy}, 8'h01);
        hold(1'b1, 4);
        chk("busy_after_glitch", {7'd0, rx_busy}, 8'h00);
        hold(1'b1, 12);
        send_frame(8'h3C, 1'b1);
        hold(1'b1, 8);

        // Framing error after a good byte, then a held-low break
        send_frame(8'h55, 1'b1);
        hold(1'b1, 4);
        send_frame(8'hA3, 1'b0);
        chk("busy_in_break", {7'd0, rx_busy}, 8'h01);
        hold(1'b0, 40);
        chk("busy_break_held", {7'd0, rx_busy}, 8'h01);
        chk("data_after_ferr", rx_data, 8'h55);
        hold(1'b1, 4);
        chk("busy_break_exit", {7'd0, rx_busy}, 8'h00);
        hold(1'b1, 8);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 8);
        chk("data_b2b_last", rx_data, 8'hFF);

        // Reset in data bit 4 of 0x96: partial frame discarded
        hold(1'b0, OVERSAMPLE);
        for (int i = 0; i < 4; i++) begin
            hold(((8'h96 >> i) & 8'h01) != 8'h00, OVERSAMPLE);
        end
        hold(1'b1, 8);
        rst = 1'b1;
        #2;
        chk("midrst_rx_data", rx_data, 8'h00);
        chk("midrst_rx_done", {7'd0, rx_done}, 8'h00);
        chk("midrst_frame_err", {7'd0, frame_err}, 8'h00);
        chk("midrst_parity_err", {7'd0, parity_err}, 8'h00);
        chk("midrst_rx_busy", {7'd0, rx_busy}, 8'h00);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 20);
        send_frame(8'hC3, 1'b1);
        hold(1'b1, 8);
        chk("data_after_midrst", rx_data, 8'hC3);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        send_frame_p(8'h07, 1'b0);
        hold(1'b1, 8);
        send_frame_p(8'h07, 1'b1);
        hold(1'b1, 8);
`endif

        // Every expected strobe must have been seen
        hold(1'b1, 8);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_strobes got=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
